mem_issue_queue: RTL

In-order load/store issue queue sitting directly upstream of the memory unit. It receives memory-class micro-ops from dispatch and holds them until their source operands arrive over the CDB. Each head entry is then presented as a registered one-cycle issue pulse to the memory unit. Stores issue only when they reach the ROB head, so memory is never written speculatively.

---
 rtl/mem_issue_queue_if.sv | 66 ++++++
 rtl/mem_issue_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_issue_queue_if.sv
// Bundle of dispatch, CDB, commit-head, memory-unit and issue signals for mem_issue_queue.
// The queue uses the slave modport; the driving environment uses master.
interface mem_issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;

  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      enq_pc;
  logic [31:0]      enq_inst;
  logic [31:0]      enq_imm;
  logic             enq_is_store;
  logic [TAG_W-1:0] enq_rob_idx;
  logic             enq_rs1_rdy;
  logic             enq_rs2_rdy;
  logic [TAG_W-1:0] enq_rs1_tag;
  logic [TAG_W-1:0] enq_rs2_tag;
  logic [31:0]      enq_rs1_data;
  logic [31:0]      enq_rs2_data;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_rob_idx;
  logic [31:0]      cdb_data;

  logic [TAG_W-1:0] rob_head_idx;
  logic             mem_ready;

  logic             iss_valid;
  logic [31:0]      iss_pc;
  logic [31:0]      iss_inst;
  logic [31:0]      iss_imm;
  logic [31:0]      iss_rs1_data;
  logic [31:0]      iss_rs2_data;
  logic             iss_is_store;
  logic [TAG_W-1:0] iss_rob_idx;

  logic [CW-1:0]    count;

  modport master (
    output flush,
    output enq_valid, enq_pc, enq_inst, enq_imm, enq_is_store, enq_rob_idx,
    output enq_rs1_rdy, enq_rs2_rdy, enq_rs1_tag, enq_rs2_tag, enq_rs1_data, enq_rs2_data,
    output cdb_valid, cdb_rob_idx, cdb_data,
    output rob_head_idx, mem_ready,
    input  enq_ready,
    input  iss_valid, iss_pc, iss_inst, iss_imm, iss_rs1_data, iss_rs2_data,
    input  iss_is_store, iss_rob_idx,
    input  count
  );

  modport slave (
    input  flush,
    input  enq_valid, enq_pc, enq_inst, enq_imm, enq_is_store, enq_rob_idx,
    input  enq_rs1_rdy, enq_rs2_rdy, enq_rs1_tag, enq_rs2_tag, enq_rs1_data, enq_rs2_data,
    input  cdb_valid, cdb_rob_idx, cdb_data,
    input  rob_head_idx, mem_ready,
    output enq_ready,
    output iss_valid, iss_pc, iss_inst, iss_imm, iss_rs1_data, iss_rs2_data,
    output iss_is_store, iss_rob_idx,
    output count
  );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: holds memory ops until operands arrive on the CDB,
// then issues the head as a registered one-cycle pulse; stores wait for the ROB head.
module mem_issue_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              rst,
  mem_issue_queue_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [31:0]      imm;
    logic             is_store;
    logic [TAG_W-1:0] rob_idx;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs1_data;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs2_data;
  } entry_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [31:0]      imm;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic             is_store;
    logic [TAG_W-1:0] rob_idx;
  } iss_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             iss_valid_q, iss_valid_d;
  iss_t             iss_q, iss_d;

  entry_t           head_ent;
  entry_t           new_ent;
  logic             enq_ready;
  logic             do_enq;
  logic             do_issue;
  logic             store_ok;

  assign enq_ready = (count_q != CW'(DEPTH));
  assign do_enq    = io.enq_valid && enq_ready;
  assign head_ent  = ent_q[head_q];

  // Eligibility looks only at registered state; the iss_valid_q term enforces the idle gap.
  always_comb begin
    store_ok = 1'b1;
    if (head_ent.is_store) begin
      store_ok = head_ent.rs2_rdy && (head_ent.rob_idx == io.rob_head_idx);
    end
    do_issue = valid_q[head_q] && head_ent.rs1_rdy && io.mem_ready &&
               !iss_valid_q && store_ok;
  end

  // Incoming op, with a same-cycle CDB snoop so a wakeup is never lost at enqueue.
  always_comb begin
    new_ent          = '0;
    new_ent.pc       = io.enq_pc;
    new_ent.inst     = io.enq_inst;
    new_ent.imm      = io.enq_imm;
    new_ent.is_store = io.enq_is_store;
    new_ent.rob_idx  = io.enq_rob_idx;
    new_ent.rs1_rdy  = io.enq_rs1_rdy;
    new_ent.rs1_tag  = io.enq_rs1_tag;
    new_ent.rs1_data = io.enq_rs1_data;
    new_ent.rs2_rdy  = io.enq_rs2_rdy;
    new_ent.rs2_tag  = io.enq_rs2_tag;
    new_ent.rs2_data = io.enq_rs2_data;
    if (io.cdb_valid && !io.enq_rs1_rdy && (io.enq_rs1_tag == io.cdb_rob_idx)) begin
      new_ent.rs1_rdy  = 1'b1;
      new_ent.rs1_data = io.cdb_data;
    end
    if (io.cdb_valid && !io.enq_rs2_rdy && (io.enq_rs2_tag == io.cdb_rob_idx)) begin
      new_ent.rs2_rdy  = 1'b1;
      new_ent.rs2_data = io.cdb_data;
    end
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && io.cdb_valid) begin
        if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == io.cdb_rob_idx)) begin
          ent_d[i].rs1_rdy  = 1'b1;
          ent_d[i].rs1_data = io.cdb_data;
        end
        if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == io.cdb_rob_idx)) begin
          ent_d[i].rs2_rdy  = 1'b1;
          ent_d[i].rs2_data = io.cdb_data;
        end
      end
    end
    if (do_enq) begin
      ent_d[tail_q] = new_ent;
    end
  end

  // Flush wins over everything else happening at the same edge.
  always_comb begin
    valid_d     = valid_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    iss_valid_d = do_issue;
    iss_d       = iss_q;

    if (do_issue) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
      iss_d.pc        = head_ent.pc;
      iss_d.inst      = head_ent.inst;
      iss_d.imm       = head_ent.imm;
      iss_d.rs1_data  = head_ent.rs1_data;
      iss_d.rs2_data  = head_ent.rs2_data;
      iss_d.is_store  = head_ent.is_store;
      iss_d.rob_idx   = head_ent.rob_idx;
    end

    if (do_enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end

    case ({do_enq, do_issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (io.flush) begin
      valid_d     = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
    end
  end

  // Payload storage carries no reset; it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign io.enq_ready    = enq_ready;
  assign io.count        = count_q;
  assign io.iss_valid    = iss_valid_q;
  assign io.iss_pc       = iss_q.pc;
  assign io.iss_inst     = iss_q.inst;
  assign io.iss_imm      = iss_q.imm;
  assign io.iss_rs1_data = iss_q.rs1_data;
  assign io.iss_rs2_data = iss_q.rs2_data;
  assign io.iss_is_store = iss_q.is_store;
  assign io.iss_rob_idx  = iss_q.rob_idx;

endmodule
